icache_mshr_file: RTL and testbench
===================================

// Module: icache_mshr_file
// PURPOSE
//  Parametrised miss-status holding register file for the icache miss path; sits between tag-compare/miss detect and the downstream refill port.
//  Tracks ENTRY_NUM outstanding misses and merges same-line misses into the primary entry's hit_bitmap so that each line issues only one downstream request.
//  Replays one upstream response per original request once refill completes; the data buffer is indexed by the primary entry index.
// PARAMETERS
//  ENTRY_NUM    8   MSHR entries; IDX_W = $clog2(ENTRY_NUM)
//  ADDR_WIDTH   32  request address width
//  OFFSET_WIDTH 6   line offset bits; line address = addr[ADDR_WIDTH-1:OFFSET_WIDTH]
//  TXNID_WIDTH  5   upstream transaction id width
//  WAY_NUM      2   cache ways; WAY_W = $clog2(WAY_NUM) (minimum 1)
// PORTS
//  clk            in   1            clock
//  rst_n          in   1            reset, asynchronous, active low
//  alloc_vld      in   1            miss request valid
//  alloc_rdy      out  1            entry free available (=|~entry_valid)
//  alloc_addr     in   ADDR_WIDTH   miss address
//  alloc_txnid    in   TXNID_WIDTH  upstream txnid
//  alloc_way      in   WAY_W        victim way chosen by replacement
//  ds_req_vld     out  1            downstream refill request
//  ds_req_rdy     in   1            downstream accepts
//  ds_req_addr    out  ADDR_WIDTH   line-aligned address (offset bits = 0)
//  ds_req_txnid   out  IDX_W        primary entry index
//  ds_rsp_vld     in   1            refill complete (data already written to buffer[txnid])
//  ds_rsp_txnid   in   IDX_W        entry index being completed
//  up_rsp_vld     out  1            upstream response ready
//  up_rsp_rdy     in   1            upstream accepts
//  up_rsp_txnid   out  TXNID_WIDTH  original request txnid
//  up_rsp_offset  out  OFFSET_WIDTH original request offset
//  up_rsp_buf_idx out  IDX_W        primary entry index (data buffer select)
//  up_rsp_way     out  WAY_W        way to be filled
//  err_unexp_rsp  out  1            sticky: ds_rsp to an entry not in WAIT_RSP
// BEHAVIOUR
//  Reset: every entry is IDLE, hit_bitmap is 0, and both locks are clear. All outputs are 0, except alloc_rdy=1 (it is combinational from entry state).
//  Per-entry states: IDLE -> ISSUE (primary) -> WAIT_RSP -> READY -> IDLE; a secondary entry goes IDLE -> MERGED -> READY -> IDLE.
//  Allocation (alloc_vld&alloc_rdy): lowest IDLE entry is written.
//   - If any valid primary entry has an equal line address, the new entry is MERGED. Its prim_idx is set to that primary, and the primary's hit_bitmap[new] is set.
//   - Otherwise the new entry is ISSUE with prim_idx = itself.
//   - If that primary receives ds_rsp in the same cycle, or is already READY, the new entry enters READY directly.
//   - An entry freed in cycle N is not allocatable before N+1, because alloc_rdy is computed from registered state.
//  Downstream issue: the lowest ISSUE entry drives ds_req the cycle after allocation.
//   - Once ds_req_vld is high, the selected index is locked, and addr/txnid stay stable until ds_req_rdy.
//   - On handshake the entry moves to WAIT_RSP.
//  Refill: ds_rsp_vld with an entry in WAIT_RSP moves that entry, and every entry set in its hit_bitmap, to READY at the next edge.
//   - A ds_rsp to any other state is ignored and sets err_unexp_rsp. Only rst_n clears it.
//  Upstream drain: the candidate is the lowest READY entry, excluding primaries with hit_bitmap!=0, so a primary always drains last and its buffer stays live.
//   - The selection is locked while up_rsp_vld&!up_rsp_rdy.
//   - On handshake the entry goes IDLE. A secondary also clears its bit in its primary's hit_bitmap in the same edge.
//   - Throughput is 1 response per cycle.
//  Simultaneous events in one cycle (alloc, ds handshake, ds_rsp, up handshake) all take effect on the same edge without loss.
//  Latency, minimum:
//   - alloc in cycle N -> ds_req_vld in N+1.
//   - ds_rsp in cycle M -> up_rsp_vld in M+1.
//  Full: alloc_rdy=0 while all entries are valid; a merge also needs a free entry.
//  Reset mid-operation: all entries are dropped with no responses. Buffers outside this block are not cleared.
// TESTING
//  1 Single miss: alloc 0x1000_0040 txn 3 way 1 -> ds_req_vld next cycle with addr 0x1000_0040 and txnid 0. Then ds_rsp txnid 0 -> up_rsp txn 3, offset 0, buf 0, way 1 the following cycle.
//  2 Merge: allocs 0x2000_0004 txn1, 0x2000_0010 txn2, 0x2000_0030 txn3 -> exactly one ds_req. After ds_rsp 0, up_rsp order is txn2, txn3, then txn1, all with buf_idx 0.
//  3 Full: 8 distinct-line allocs -> alloc_rdy=0. Freeing entry 5 makes alloc_rdy=1 next cycle, and the next alloc lands in entry 5.
//  4 Backpressure: hold ds_req_rdy=0 for 10 cycles while allocating a lower-index line -> ds_req addr/txnid stay unchanged until the handshake.
//  5 Same-cycle: a merging alloc on the exact cycle of the primary's ds_rsp -> the new entry is READY next cycle, and the primary waits for it.
//  6 Error/reset: ds_rsp txnid 4 with entry 4 IDLE -> err_unexp_rsp=1 and stays set. Asserting rst_n low mid-drain -> all outputs 0 and alloc_rdy=1 immediately.

Source files
------------

// File: rtl/icache_mshr_file.sv
// Miss-status holding registers for the icache: merges same-line misses and replays one response per request.
// Latency: alloc -> ds_req_vld next cycle; ds_rsp -> up_rsp_vld next cycle; up drain 1 response/cycle.
// Backpressure: alloc_rdy drops when all entries are busy; ds_req and up_rsp selections stay locked while stalled.
module icache_mshr_file #(
    parameter int ENTRY_NUM    = 8,
    parameter int ADDR_WIDTH   = 32,
    parameter int OFFSET_WIDTH = 6,
    parameter int TXNID_WIDTH  = 5,
    parameter int WAY_NUM      = 2
) (
    input  logic                                              clk,
    input  logic                                              rst_n,
    input  logic                                              alloc_vld,
    output logic                                              alloc_rdy,
    input  logic [ADDR_WIDTH-1:0]                             alloc_addr,
    input  logic [TXNID_WIDTH-1:0]                            alloc_txnid,
    input  logic [(WAY_NUM > 1 ? $clog2(WAY_NUM) : 1)-1:0]    alloc_way,
    output logic                                              ds_req_vld,
    input  logic                                              ds_req_rdy,
    output logic [ADDR_WIDTH-1:0]                             ds_req_addr,
    output logic [$clog2(ENTRY_NUM)-1:0]                      ds_req_txnid,
    input  logic                                              ds_rsp_vld,
    input  logic [$clog2(ENTRY_NUM)-1:0]                      ds_rsp_txnid,
    output logic                                              up_rsp_vld,
    input  logic                                              up_rsp_rdy,
    output logic [TXNID_WIDTH-1:0]                            up_rsp_txnid,
    output logic [OFFSET_WIDTH-1:0]                           up_rsp_offset,
    output logic [$clog2(ENTRY_NUM)-1:0]                      up_rsp_buf_idx,
    output logic [(WAY_NUM > 1 ? $clog2(WAY_NUM) : 1)-1:0]    up_rsp_way,
    output logic                                              err_unexp_rsp
);
    localparam int IDX_W  = $clog2(ENTRY_NUM);
    localparam int WAY_W  = (WAY_NUM > 1) ? $clog2(WAY_NUM) : 1;
    localparam int LINE_W = ADDR_WIDTH - OFFSET_WIDTH;

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_MERGED, S_READY} state_e;

    state_e                   state_q [ENTRY_NUM];
    state_e                   state_d [ENTRY_NUM];
    logic [LINE_W-1:0]        line_q  [ENTRY_NUM];
    logic [LINE_W-1:0]        line_d  [ENTRY_NUM];
    logic [TXNID_WIDTH-1:0]   txn_q   [ENTRY_NUM];
    logic [TXNID_WIDTH-1:0]   txn_d   [ENTRY_NUM];
    logic [OFFSET_WIDTH-1:0]  off_q   [ENTRY_NUM];
    logic [OFFSET_WIDTH-1:0]  off_d   [ENTRY_NUM];
    logic [WAY_W-1:0]         way_q   [ENTRY_NUM];
    logic [WAY_W-1:0]         way_d   [ENTRY_NUM];
    logic [IDX_W-1:0]         prim_q  [ENTRY_NUM];
    logic [IDX_W-1:0]         prim_d  [ENTRY_NUM];
    logic [ENTRY_NUM-1:0]     hit_q   [ENTRY_NUM];
    logic [ENTRY_NUM-1:0]     hit_d   [ENTRY_NUM];

    logic             ds_lock_q, ds_lock_d, up_lock_q, up_lock_d, err_q, err_d;
    logic [IDX_W-1:0] ds_idx_q, ds_idx_d, up_idx_q, up_idx_d;

    logic             free_any, ds_any, up_any, match_vld, rsp_hit;
    logic [IDX_W-1:0] alloc_idx, match_idx, ds_idx, up_idx;
    logic [LINE_W-1:0] alloc_line;

    assign alloc_line = alloc_addr[ADDR_WIDTH-1:OFFSET_WIDTH];

    always_comb begin
        free_any  = 1'b0;
        ds_any    = 1'b0;
        up_any    = 1'b0;
        match_vld = 1'b0;
        alloc_idx = '0;
        match_idx = '0;
        ds_idx    = ds_idx_q;
        up_idx    = up_idx_q;
        // Descending scans so the lowest qualifying index wins.
        for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
            if (state_q[i] == S_IDLE) begin
                free_any  = 1'b1;
                alloc_idx = IDX_W'(i);
            end
            if (state_q[i] == S_ISSUE) begin
                ds_any = 1'b1;
                if (!ds_lock_q) ds_idx = IDX_W'(i);
            end
            if (state_q[i] == S_READY && (prim_q[i] != IDX_W'(i) || hit_q[i] == '0)) begin
                up_any = 1'b1;
                if (!up_lock_q) up_idx = IDX_W'(i);
            end
        end
        // A primary already presented upstream is about to leave; a same-line miss must not merge into it.
        for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
            if (state_q[i] != S_IDLE && prim_q[i] == IDX_W'(i) && line_q[i] == alloc_line &&
                !(up_any && up_idx == IDX_W'(i))) begin
                match_vld = 1'b1;
                match_idx = IDX_W'(i);
            end
        end
    end

    assign alloc_rdy  = free_any;
    assign ds_req_vld = ds_any;
    assign up_rsp_vld = up_any;
    assign rsp_hit    = ds_rsp_vld && state_q[ds_rsp_txnid] == S_WAIT;

    always_comb begin
        state_d   = state_q;
        line_d    = line_q;
        txn_d     = txn_q;
        off_d     = off_q;
        way_d     = way_q;
        prim_d    = prim_q;
        hit_d     = hit_q;
        err_d     = err_q || (ds_rsp_vld && !rsp_hit);
        ds_lock_d = ds_any && !ds_req_rdy;
        ds_idx_d  = ds_idx;
        up_lock_d = up_any && !up_rsp_rdy;
        up_idx_d  = up_idx;

        if (rsp_hit) begin
            state_d[ds_rsp_txnid] = S_READY;
            for (int j = 0; j < ENTRY_NUM; j++) begin
                if (hit_q[ds_rsp_txnid][j]) state_d[j] = S_READY;
            end
        end
        if (ds_any && ds_req_rdy) state_d[ds_idx] = S_WAIT;
        if (up_any && up_rsp_rdy) begin
            state_d[up_idx] = S_IDLE;
            if (prim_q[up_idx] != up_idx) hit_d[prim_q[up_idx]][up_idx] = 1'b0;
        end
        if (alloc_vld && free_any) begin
            line_d[alloc_idx] = alloc_line;
            txn_d[alloc_idx]  = alloc_txnid;
            off_d[alloc_idx]  = alloc_addr[OFFSET_WIDTH-1:0];
            way_d[alloc_idx]  = alloc_way;
            hit_d[alloc_idx]  = '0;
            if (match_vld) begin
                prim_d[alloc_idx] = match_idx;
                hit_d[match_idx][alloc_idx] = 1'b1;
                state_d[alloc_idx] = (state_q[match_idx] == S_READY ||
                                      (rsp_hit && ds_rsp_txnid == match_idx)) ? S_READY : S_MERGED;
            end else begin
                prim_d[alloc_idx]  = alloc_idx;
                state_d[alloc_idx] = S_ISSUE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRY_NUM; i++) begin
                state_q[i] <= S_IDLE;
                line_q[i]  <= '0;
                txn_q[i]   <= '0;
                off_q[i]   <= '0;
                way_q[i]   <= '0;
                prim_q[i]  <= '0;
                hit_q[i]   <= '0;
            end
            ds_lock_q <= 1'b0;
            ds_idx_q  <= '0;
            up_lock_q <= 1'b0;
            up_idx_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            line_q    <= line_d;
            txn_q     <= txn_d;
            off_q     <= off_d;
            way_q     <= way_d;
            prim_q    <= prim_d;
            hit_q     <= hit_d;
            ds_lock_q <= ds_lock_d;
            ds_idx_q  <= ds_idx_d;
            up_lock_q <= up_lock_d;
            up_idx_q  <= up_idx_d;
            err_q     <= err_d;
        end
    end

    assign ds_req_addr    = ds_any ? {line_q[ds_idx], {OFFSET_WIDTH{1'b0}}} : '0;
    assign ds_req_txnid   = ds_any ? ds_idx : '0;
    assign up_rsp_txnid   = up_any ? txn_q[up_idx] : '0;
    assign up_rsp_offset  = up_any ? off_q[up_idx] : '0;
    assign up_rsp_buf_idx = up_any ? prim_q[up_idx] : '0;
    assign up_rsp_way     = up_any ? way_q[up_idx] : '0;
    assign err_unexp_rsp  = err_q;
endmodule

// File: tb/tb_icache_mshr_file.sv
// Scoreboard bench for icache_mshr_file: expected upstream responses are queued at stimulus time
// and popped by a monitor on each up_rsp handshake; directed checks cover issue, lock, full and error paths.
module tb_icache_mshr_file;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        alloc_vld, alloc_rdy;
    logic [31:0] alloc_addr;
    logic [4:0]  alloc_txnid;
    logic [0:0]  alloc_way;
    logic        ds_req_vld, ds_req_rdy;
    logic [31:0] ds_req_addr;
    logic [2:0]  ds_req_txnid;
    logic        ds_rsp_vld;
    logic [2:0]  ds_rsp_txnid;
    logic        up_rsp_vld, up_rsp_rdy;
    logic [4:0]  up_rsp_txnid;
    logic [5:0]  up_rsp_offset;
    logic [2:0]  up_rsp_buf_idx;
    logic [0:0]  up_rsp_way;
    logic        err_unexp_rsp;

    typedef struct {
        logic [4:0] txn;
        logic [5:0] off;
        logic [2:0] bidx;
        logic [0:0] way;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    icache_mshr_file dut (
        .clk(clk), .rst_n(rst_n),
        .alloc_vld(alloc_vld), .alloc_rdy(alloc_rdy), .alloc_addr(alloc_addr),
        .alloc_txnid(alloc_txnid), .alloc_way(alloc_way),
        .ds_req_vld(ds_req_vld), .ds_req_rdy(ds_req_rdy), .ds_req_addr(ds_req_addr),
        .ds_req_txnid(ds_req_txnid),
        .ds_rsp_vld(ds_rsp_vld), .ds_rsp_txnid(ds_rsp_txnid),
        .up_rsp_vld(up_rsp_vld), .up_rsp_rdy(up_rsp_rdy), .up_rsp_txnid(up_rsp_txnid),
        .up_rsp_offset(up_rsp_offset), .up_rsp_buf_idx(up_rsp_buf_idx), .up_rsp_way(up_rsp_way),
        .err_unexp_rsp(err_unexp_rsp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [4:0] txn, input logic [5:0] off, input logic [2:0] bidx, input logic [0:0] way);
        exp_t e;
        e.txn = txn; e.off = off; e.bidx = bidx; e.way = way;
        sb.push_back(e);
    endtask

    task automatic do_alloc(input logic [31:0] addr, input logic [4:0] txn, input logic [0:0] way);
        alloc_addr  = addr;
        alloc_txnid = txn;
        alloc_way   = way;
        alloc_vld   = 1'b1;
        tick();
        alloc_vld   = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        sb.delete();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic wait_drain();
        for (int n = 0; n < 50 && sb.size() != 0; n++) tick();
        chk("drain_left", sb.size(), 0);
    endtask

    always @(negedge clk) begin
        if (rst_n && up_rsp_vld && up_rsp_rdy) begin
            if (sb.size() == 0) begin
                chk("up_unexpected", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("up_txnid", up_rsp_txnid, e.txn);
                chk("up_offset", up_rsp_offset, e.off);
                chk("up_buf_idx", up_rsp_buf_idx, e.bidx);
                chk("up_way", up_rsp_way, e.way);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; alloc_vld = 1'b0; alloc_addr = '0; alloc_txnid = '0; alloc_way = '0;
        ds_req_rdy = 1'b0; ds_rsp_vld = 1'b0; ds_rsp_txnid = '0; up_rsp_rdy = 1'b0;
        tick();
        tick();
        chk("rst_alloc_rdy", alloc_rdy, 1);
        chk("rst_ds_vld", ds_req_vld, 0);
        chk("rst_ds_addr", ds_req_addr, 0);
        chk("rst_up_vld", up_rsp_vld, 0);
        chk("rst_err", err_unexp_rsp, 0);
        rst_n = 1'b1;
        tick();

        // single miss
        up_rsp_rdy = 1'b1;
        push(5'd3, 6'h00, 3'd0, 1'b1);
        do_alloc(32'h1000_0040, 5'd3, 1'b1);
        chk("t1_ds_vld", ds_req_vld, 1);
        chk("t1_ds_addr", ds_req_addr, 32'h1000_0040);
        chk("t1_ds_txnid", ds_req_txnid, 0);
        ds_req_rdy = 1'b1;
        tick();
        ds_req_rdy = 1'b0;
        chk("t1_ds_done", ds_req_vld, 0);
        ds_rsp_vld = 1'b1; ds_rsp_txnid = 3'd0;
        tick();
        ds_rsp_vld = 1'b0;
        chk("t1_up_vld", up_rsp_vld, 1);
        wait_drain();

        // merge of three same-line misses
        push(5'd2, 6'h10, 3'd0, 1'b0);
        push(5'd3, 6'h30, 3'd0, 1'b1);
        push(5'd1, 6'h04, 3'd0, 1'b1);
        do_alloc(32'h2000_0004, 5'd1, 1'b1);
        do_alloc(32'h2000_0010, 5'd2, 1'b0);
        do_alloc(32'h2000_0030, 5'd3, 1'b1);
        chk("t2_ds_vld", ds_req_vld, 1);
        chk("t2_ds_addr", ds_req_addr, 32'h2000_0000);
        chk("t2_ds_txnid", ds_req_txnid, 0);
        ds_req_rdy = 1'b1;
        tick();
        ds_req_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("t2_one_req", ds_req_vld, 0);
            tick();
        end
        ds_rsp_vld = 1'b1; ds_rsp_txnid = 3'd0;
        tick();
        ds_rsp_vld = 1'b0;
        wait_drain();

        // full, then free entry 5
        do_reset();
        up_rsp_rdy = 1'b1;
        ds_req_rdy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            logic [31:0] a;
            a = 32'h3000_0000 + 32'(i) * 32'h40;
            do_alloc(a, 5'(i), 1'(i));
        end
        chk("t3_full", alloc_rdy, 0);
        repeat (10) tick();
        push(5'd5, 6'h00, 3'd5, 1'b1);
        ds_rsp_vld = 1'b1; ds_rsp_txnid = 3'd5;
        tick();
        ds_rsp_vld = 1'b0;
        chk("t3_not_yet", alloc_rdy, 0);
        tick();
        chk("t3_freed", alloc_rdy, 1);
        chk("t3_sb", sb.size(), 0);
        do_alloc(32'h3000_1000, 5'd20, 1'b0);
        chk("t3_ds_vld", ds_req_vld, 1);
        chk("t3_ds_txnid", ds_req_txnid, 5);
        chk("t3_ds_addr", ds_req_addr, 32'h3000_1000);

        // ds_req lock under backpressure
        do_reset();
        up_rsp_rdy = 1'b1;
        ds_req_rdy = 1'b0;
        push(5'd10, 6'h00, 3'd0, 1'b0);
        alloc_addr = 32'h4000_0000; alloc_txnid = 5'd10; alloc_way = 1'b0; alloc_vld = 1'b1;
        tick();
        alloc_addr = 32'h4000_0100; alloc_txnid = 5'd11;
        ds_req_rdy = 1'b1;
        tick();
        alloc_vld = 1'b0;
        ds_req_rdy = 1'b0;
        ds_rsp_vld = 1'b1; ds_rsp_txnid = 3'd0;
        tick();
        ds_rsp_vld = 1'b0;
        tick();
        chk("t4_sb", sb.size(), 0);
        do_alloc(32'h4000_0080, 5'd12, 1'b0);
        for (int i = 0; i < 10; i++) begin
            chk("t4_lock_txnid", ds_req_txnid, 1);
            chk("t4_lock_addr", ds_req_addr, 32'h4000_0100);
            tick();
        end
        ds_req_rdy = 1'b1;
        tick();
        ds_req_rdy = 1'b0;
        chk("t4_next_txnid", ds_req_txnid, 0);
        chk("t4_next_addr", ds_req_addr, 32'h4000_0080);

        // merge on the same cycle as the primary's refill
        do_reset();
        up_rsp_rdy = 1'b0;
        ds_req_rdy = 1'b1;
        do_alloc(32'h5000_0020, 5'd7, 1'b1);
        tick();
        ds_req_rdy = 1'b0;
        alloc_addr = 32'h5000_0008; alloc_txnid = 5'd8; alloc_way = 1'b1; alloc_vld = 1'b1;
        ds_rsp_vld = 1'b1; ds_rsp_txnid = 3'd0;
        tick();
        alloc_vld = 1'b0;
        ds_rsp_vld = 1'b0;
        chk("t5_up_vld", up_rsp_vld, 1);
        chk("t5_up_txnid", up_rsp_txnid, 8);
        chk("t5_up_buf", up_rsp_buf_idx, 0);
        push(5'd8, 6'h08, 3'd0, 1'b1);
        push(5'd7, 6'h20, 3'd0, 1'b1);
        up_rsp_rdy = 1'b1;
        wait_drain();

        // unexpected refill, then reset mid-drain
        do_reset();
        ds_rsp_vld = 1'b1; ds_rsp_txnid = 3'd4;
        tick();
        ds_rsp_vld = 1'b0;
        chk("t6_err_set", err_unexp_rsp, 1);
        repeat (5) tick();
        chk("t6_err_sticky", err_unexp_rsp, 1);
        up_rsp_rdy = 1'b0;
        ds_req_rdy = 1'b1;
        do_alloc(32'h6000_0000, 5'd1, 1'b0);
        do_alloc(32'h6000_0004, 5'd2, 1'b0);
        ds_req_rdy = 1'b0;
        ds_rsp_vld = 1'b1; ds_rsp_txnid = 3'd0;
        tick();
        ds_rsp_vld = 1'b0;
        chk("t6_up_vld", up_rsp_vld, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_up_vld", up_rsp_vld, 0);
        chk("t6_rst_up_txnid", up_rsp_txnid, 0);
        chk("t6_rst_ds_vld", ds_req_vld, 0);
        chk("t6_rst_alloc_rdy", alloc_rdy, 1);
        chk("t6_rst_err", err_unexp_rsp, 0);
        up_rsp_rdy = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();
        chk("t6_dropped", up_rsp_vld, 0);
        chk("sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
